// File: rtl/alu_selftest_pkg.sv
// Shared definitions for the ALU self-test engine.
//   - opcode constants for the eight ALU operations
//   - FSM state enum
//   - EXP_LED: expected active-low LED pattern per opcode for the ALU's
//     built-in operands a=4'b0101, b=4'b0010
//   - bit positions of the flag LEDs on the active-low LED bus
package alu_selftest_pkg;

  typedef logic [2:0] opcode_t;
  typedef logic [7:0] led_t;

  localparam opcode_t OP_PASS = 3'd0;
  localparam opcode_t OP_ADD  = 3'd1;
  localparam opcode_t OP_SUBA = 3'd2;
  localparam opcode_t OP_SUBB = 3'd3;
  localparam opcode_t OP_NOT  = 3'd4;
  localparam opcode_t OP_AND  = 3'd5;
  localparam opcode_t OP_OR   = 3'd6;
  localparam opcode_t OP_XOR  = 3'd7;

  // LED bus layout: {~cf, ~ovf, ~zf, ~nf, ~y[3:0]}
  localparam int LED_CF  = 7;
  localparam int LED_OVF = 6;
  localparam int LED_ZF  = 5;
  localparam int LED_NF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Indexed by opcode, in order PASS, ADD, SUBA, SUBB, NOT, AND, OR, XOR.
  localparam led_t EXP_LED [8] = '{
    8'hFA, 8'hF8, 8'hFC, 8'h62, 8'hE5, 8'hDF, 8'hF8, 8'hF8
  };

endpackage

// File: rtl/alu_selftest_if.sv
// Bus between the self-test engine and the ALU under test.
//   alusel : opcode select driven to the ALU
//   led_in : active-low LED bus returned by the ALU
// master = self-test engine, slave = ALU.
interface alu_selftest_if;
  import alu_selftest_pkg::*;

  opcode_t alusel;
  led_t    led_in;

  modport master (output alusel, input led_in);
  modport slave  (input alusel, output led_in);
endinterface

// File: rtl/alu_selftest_led_decode.sv
// Combinational decode of one LED-bus sample.
//   led_in, alusel   : raw active-low sample and the opcode that produced it
//   y, cf, ovf, zf, nf : decoded result and flags (active-high)
//   mismatch         : sample differs from EXP_LED[alusel]
//   inconsistent     : zf disagrees with y==0, or nf disagrees with y[3]
module alu_led_decode
  import alu_selftest_pkg::*;
(
  input  led_t       led_in,
  input  opcode_t    alusel,
  output logic [3:0] y,
  output logic       cf,
  output logic       ovf,
  output logic       zf,
  output logic       nf,
  output logic       mismatch,
  output logic       inconsistent
);

  assign y   = ~led_in[3:0];
  assign cf  = ~led_in[LED_CF];
  assign ovf = ~led_in[LED_OVF];
  assign zf  = ~led_in[LED_ZF];
  assign nf  = ~led_in[LED_NF];

  assign mismatch = (led_in != EXP_LED[alusel]);

  // The flags must agree with the result nibble regardless of the opcode,
  // which catches broken LED wiring even where the table would not.
  assign inconsistent = (zf != (y == 4'd0)) || (nf != y[3]);

endmodule

// File: rtl/alu_selftest.sv
// Sequential self-test engine for the 4-bit ALU.
// Steps the opcode through 0..7, holds each for SETTLE_CYC cycles, samples
// the active-low LED bus and compares against the expected table.
//   clk, rst  : clock, synchronous active-high reset
//   start     : single-cycle run request (accepted in IDLE or DONE)
//   alu       : master side of the ALU bus (alusel out, led_in in)
//   busy      : run in progress
//   done      : run finished, results valid; held until next start/rst
//   pass      : while done, no mismatches and no flag inconsistency
//   err_cnt   : number of mismatching opcodes (0..8)
//   fail_op   : opcode of first mismatch (0 if none)
//   fail_led  : raw LED sample at first mismatch (0 if none)
//   cons_err  : sticky flag/result inconsistency seen in any sample
module alu_selftest
  import alu_selftest_pkg::*;
#(
  parameter int SETTLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  alu_selftest_if.master alu,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [3:0]   err_cnt,
  output opcode_t      fail_op,
  output led_t         fail_led,
  output logic         cons_err
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  opcode_t    alusel_reg, alusel_next;
  logic [3:0] err_cnt_reg, err_cnt_next;
  opcode_t    fail_op_reg, fail_op_next;
  led_t       fail_led_reg, fail_led_next;
  logic       cons_err_reg, cons_err_next;

  logic       mismatch;
  logic       inconsistent;

  // Individual decoded fields are only needed inside the decoder.
  logic [3:0] unused_y;
  logic       unused_cf, unused_ovf, unused_zf, unused_nf;

  alu_led_decode u_decode (
    .led_in       (alu.led_in),
    .alusel       (alusel_reg),
    .y            (unused_y),
    .cf           (unused_cf),
    .ovf          (unused_ovf),
    .zf           (unused_zf),
    .nf           (unused_nf),
    .mismatch     (mismatch),
    .inconsistent (inconsistent)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      alusel_reg   <= OP_PASS;
      err_cnt_reg  <= '0;
      fail_op_reg  <= OP_PASS;
      fail_led_reg <= '0;
      cons_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      alusel_reg   <= alusel_next;
      err_cnt_reg  <= err_cnt_next;
      fail_op_reg  <= fail_op_next;
      fail_led_reg <= fail_led_next;
      cons_err_reg <= cons_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    alusel_next   = alusel_reg;
    err_cnt_next  = err_cnt_reg;
    fail_op_next  = fail_op_reg;
    fail_led_next = fail_led_reg;
    cons_err_next = cons_err_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next    = ST_SETTLE;
          cnt_next      = '0;
          alusel_next   = OP_PASS;
          err_cnt_next  = '0;
          fail_op_next  = OP_PASS;
          fail_led_next = '0;
          cons_err_next = 1'b0;
        end
      end

      ST_SETTLE: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == SETTLE_LAST) begin
          state_next = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          err_cnt_next = err_cnt_reg + 4'd1;
          // err_cnt still zero means this is the first mismatch of the run.
          if (err_cnt_reg == 4'd0) begin
            fail_op_next  = alusel_reg;
            fail_led_next = alu.led_in;
          end
        end
        if (inconsistent) begin
          cons_err_next = 1'b1;
        end
        if (alusel_reg == OP_XOR) begin
          state_next = ST_DONE;
        end else begin
          alusel_next = alusel_reg + 3'd1;
          cnt_next    = '0;
          state_next  = ST_SETTLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign alu.alusel = alusel_reg;
  assign busy       = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE);
  assign done       = (state_reg == ST_DONE);
  assign pass       = done && (err_cnt_reg == 4'd0) && !cons_err_reg;
  assign err_cnt    = err_cnt_reg;
  assign fail_op    = fail_op_reg;
  assign fail_led   = fail_led_reg;
  assign cons_err   = cons_err_reg;

endmodule
